xor8_stream_unit: RTL and testbench

//  Clocked, handshaked XOR responder for the 8-bit ALU datapath.

---
 rtl/xor8_stream_unit.sv | 93 +++++++++
 tb/tb_xor8_stream_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/xor8_stream_unit.sv
// Handshaked XOR responder: computes a ^ b with zero/parity flags and
// returns results in acceptance order through a small result FIFO.
module xor8_stream_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_z,
    output logic                     out_zero,
    output logic                     out_parity,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [15:0]              done_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int EW = WIDTH + 2;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   fill_q, fill_d;
    logic [15:0]   done_q, done_d;

    logic             push, pop;
    logic [WIDTH-1:0] z_new;
    logic [EW-1:0]    entry_new;
    logic [EW-1:0]    head;

    assign in_ready  = (fill_q != FULL);
    assign out_valid = (fill_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign z_new     = in_a ^ in_b;
    assign entry_new = {z_new, ~|z_new, ^z_new};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        done_d   = done_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            done_d   = done_q + 16'd1;
        end
        unique case ({push, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            done_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            done_q   <= done_d;
        end
    end

    // Storage needs no reset: its contents are only visible while fill != 0.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= entry_new;
        end
    end

    assign head       = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_z      = head[EW-1:2];
    assign out_zero   = head[1];
    assign out_parity = head[0];
    assign fill       = fill_q;
    assign done_cnt   = done_q;

endmodule

// File: tb/tb_xor8_stream_unit.sv
// Randomized and directed bench for xor8_stream_unit against a
// queue-based reference model of the result FIFO.
module tb_xor8_stream_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_z;
    logic       out_zero;
    logic       out_parity;
    logic [2:0] fill;
    logic [15:0] done_cnt;

    int tests = 0;
    int fails = 0;
    int max_fill = 0;

    logic [7:0] mq[$];
    int         mdone = 0;

    xor8_stream_unit #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_z      (out_z),
        .out_zero   (out_zero),
        .out_parity (out_parity),
        .fill       (fill),
        .done_cnt   (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model mid-cycle,
    // then advance the model by what the edge should have done.
    task automatic step(input logic v, input logic [7:0] a,
                        input logic [7:0] b, input logic r,
                        input logic rs = 1'b0);
        logic [7:0] hz;
        bit         mpush, mpop;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = r;
        rst       = rs;
        @(negedge clk);
        hz = (mq.size() != 0) ? mq[0] : 8'h00;
        chk("in_ready",  in_ready,  mq.size() != 4);
        chk("out_valid", out_valid, mq.size() != 0);
        chk("out_z",     out_z,     hz);
        chk("out_zero",  out_zero,  (mq.size() != 0) && (hz == 0));
        chk("out_par",   out_parity, ($countones(hz) % 2) == 1);
        chk("fill",      fill,      mq.size());
        chk("done_cnt",  done_cnt,  mdone % 65536);
        mpush = v && (mq.size() != 4);
        mpop  = r && (mq.size() != 0);
        @(posedge clk);
        if (rs) begin
            mq.delete();
            mdone = 0;
        end else begin
            if (mpop) begin
                void'(mq.pop_front());
                mdone++;
            end
            if (mpush) mq.push_back(a ^ b);
        end
        if (mq.size() > max_fill) max_fill = mq.size();
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 8'h00, 1'b1);
    endtask

    logic [7:0] sa [6] = '{8'h16, 8'h92, 8'h13, 8'h1A, 8'h32, 8'h16};
    logic [7:0] sb [6] = '{8'h55, 8'h47, 8'h44, 8'h05, 8'hC5, 8'h41};
    logic [7:0] sz [6] = '{8'h43, 8'hD5, 8'h57, 8'h1F, 8'hF7, 8'h57};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_z", out_z, 0);
        chk("rst_fill", fill, 0);
        chk("rst_done", done_cnt, 0);

        // Single op
        step(1'b1, 8'h12, 8'h45, 1'b1);
        chk("single_valid", out_valid, 1);
        chk("single_z", out_z, 8'h57);
        chk("single_zero", out_zero, 0);
        chk("single_par", out_parity, 1);
        step(1'b0, 8'h00, 8'h00, 1'b1);
        chk("single_done", done_cnt, 1);

        // Back-to-back stream
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, sa[i], sb[i], 1'b1);
            chk("stream_z", out_z, sz[i]);
            chk("stream_par", out_parity, 1);
        end
        step(1'b0, 8'h00, 8'h00, 1'b1);
        chk("stream_done", done_cnt, 6);

        // Zero flag
        step(1'b1, 8'h13, 8'h13, 1'b0);
        chk("zero_z", out_z, 0);
        chk("zero_flag", out_zero, 1);
        chk("zero_par", out_parity, 0);
        drain();

        // Full / backpressure
        do_reset();
        for (int i = 0; i < 5; i++)
            step(1'b1, 8'(i + 1), 8'hF0, 1'b0);
        chk("full_fill", fill, 4);
        chk("full_in_ready", in_ready, 0);
        chk("full_head", out_z, 8'hF1);
        step(1'b1, 8'hAA, 8'h55, 1'b1);
        chk("bp_fill", fill, 3);
        chk("bp_in_ready", in_ready, 1);
        chk("bp_head", out_z, 8'hF2);
        drain();

        // Wrap with alternating backpressure
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1'b1, 8'($urandom), 8'($urandom), i[0]);
        drain();
        chk("wrap_max_fill", max_fill <= 4, 1);

        // Reset mid-stream
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(i * 7), 8'h3C, 1'b0);
        chk("mid_fill3", fill, 3);
        do_reset();
        chk("mid_fill", fill, 0);
        chk("mid_valid", out_valid, 0);
        chk("mid_z", out_z, 0);
        chk("mid_done", done_cnt, 0);
        step(1'b1, 8'hC3, 8'h0F, 1'b1);
        chk("mid_after_z", out_z, 8'hCC);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0));
        drain();
        chk("rand_max_fill", max_fill <= 4, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
